trellis_soqpsk: RTL and testbench

- Simplified SOQPSK trellis detector. Takes matched-filter I/Q samples at 2 samples/symbol and runs a 2-state Viterbi detector over a ternary partial-response model (expected level (a[n]+a[n-1])/2, a=±1).
- Outputs hard bit decisions, an early ACS decision, and three selectable DAC monitor channels.
- Configured over the common register bus.
- Sits after the carrier/timing loops and feeds the bit sync/BERT path.

---
 rtl/trellis_soqpsk.sv | 169 ++++++++++++++++
 tb/tb_trellis_soqpsk.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trellis_soqpsk.sv
// trellis_soqpsk: two-state Viterbi detector for a simplified SOQPSK ternary
// partial-response model. Includes a register-exchange survivor memory, a
// register-bus config window and three DAC monitor channels.
module trellis_soqpsk #(
    parameter int unsigned TB_DEPTH  = 12,
    parameter logic [12:0] ADDR_BASE = 13'h0400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        symEn,
    input  logic        sym2xEn,
    input  logic [17:0] iIn,
    input  logic [17:0] qIn,
    input  logic        wr0,
    input  logic        wr1,
    input  logic        wr2,
    input  logic        wr3,
    input  logic [12:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [3:0]  dac0Select,
    input  logic [3:0]  dac1Select,
    input  logic [3:0]  dac2Select,
    output logic        dac0Sync,
    output logic        dac1Sync,
    output logic        dac2Sync,
    output logic [17:0] dac0Data,
    output logic [17:0] dac1Data,
    output logic [17:0] dac2Data,
    output logic        decision,
    output logic        sym2xEn_out,
    output logic        oneOrZeroPredecessor
);

    localparam int unsigned SAMPLE_W = 18;
    localparam int unsigned METRIC_W = 24;
    localparam int unsigned DAC_W    = 18;
    localparam int unsigned AMP_W    = 16;

    logic [AMP_W-1:0]    amp;
    logic [1:0]          ctrl;
    logic                bestState;
    logic [METRIC_W-1:0] metric0, metric1;
    logic [TB_DEPTH-1:0] surv0, surv1;

    logic [SAMPLE_W-1:0] sample;
    logic [METRIC_W-1:0] sampleExt, ampExt, bmUp, bmDown;
    logic [METRIC_W-1:0] cand11, cand00, diff1, diff0;
    logic                pred1, pred0;
    logic [METRIC_W-1:0] nextMetric0, nextMetric1, metricDiff;
    logic [TB_DEPTH-1:0] nextSurv0, nextSurv1;
    logic                nextBest, nextDecision;
    logic [DAC_W-1:0]    diffSat, decLevel;
    logic                addrHit;
    logic                unusedBits;

    assign addrHit    = (addr[12:4] == ADDR_BASE[12:4]);
    assign unusedBits = &{1'b0, wr2, wr3, din[31:16], addr[1:0]};
    assign dac0Sync   = sym2xEn_out;
    assign dac1Sync   = sym2xEn_out;
    assign dac2Sync   = sym2xEn_out;

    // Add-compare-select for both states; metrics wrap, compares use the sign of the difference
    always_comb begin
        sample      = (symEn ^ ctrl[1]) ? iIn : qIn;
        sampleExt   = {{(METRIC_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
        ampExt      = {{(METRIC_W-AMP_W){1'b0}}, amp};
        bmUp        = (sampleExt << 1) - (ampExt << 1);
        bmDown      = METRIC_W'(0) - (sampleExt << 1) - (ampExt << 1);
        cand11      = metric1 + bmUp;
        cand00      = metric0 + bmDown;
        diff1       = cand11 - metric0;
        diff0       = metric1 - cand00;
        // ties keep the same-polarity predecessor
        pred1       = ~diff1[METRIC_W-1];
        pred0       = ~diff0[METRIC_W-1] & (diff0 != '0);
        nextMetric1 = pred1 ? cand11 : metric0;
        nextMetric0 = pred0 ? metric1 : cand00;
        nextSurv1   = {(pred1 ? surv1[TB_DEPTH-2:0] : surv0[TB_DEPTH-2:0]), 1'b1};
        nextSurv0   = {(pred0 ? surv1[TB_DEPTH-2:0] : surv0[TB_DEPTH-2:0]), 1'b0};
        metricDiff  = nextMetric1 - nextMetric0;
        // state 1 wins only when strictly larger
        nextBest     = ~metricDiff[METRIC_W-1] & (metricDiff != '0);
        nextDecision = (nextBest ? nextSurv1[TB_DEPTH-1] : nextSurv0[TB_DEPTH-1]) ^ ctrl[0];
    end

    // Monitor levels: saturated metric difference and bipolar decision
    always_comb begin
        if (!metricDiff[METRIC_W-1] && (metricDiff[METRIC_W-2:DAC_W-1] != '0))
            diffSat = {1'b0, {(DAC_W-1){1'b1}}};
        else if (metricDiff[METRIC_W-1] && (metricDiff[METRIC_W-2:DAC_W-1] != '1))
            diffSat = {1'b1, {(DAC_W-1){1'b0}}};
        else
            diffSat = metricDiff[DAC_W-1:0];
        decLevel = nextDecision ? {1'b0, {(DAC_W-1){1'b1}}}
                                : {1'b1, {(DAC_W-2){1'b0}}, 1'b1};
    end

    function automatic logic [DAC_W-1:0] dacMux(input logic [3:0] sel);
        case (sel)
            4'd0:    dacMux = iIn;
            4'd1:    dacMux = qIn;
            4'd2:    dacMux = sample;
            4'd3:    dacMux = diffSat;
            4'd4:    dacMux = decLevel;
            default: dacMux = '0;
        endcase
    endfunction

    // Trellis state, decision outputs and DAC channels, one step per strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            metric0              <= '0;
            metric1              <= '0;
            surv0                <= '0;
            surv1                <= '0;
            bestState            <= 1'b0;
            decision             <= 1'b0;
            oneOrZeroPredecessor <= 1'b0;
            sym2xEn_out          <= 1'b0;
            dac0Data             <= '0;
            dac1Data             <= '0;
            dac2Data             <= '0;
        end else begin
            sym2xEn_out <= sym2xEn;
            if (sym2xEn) begin
                metric0              <= nextMetric0;
                metric1              <= nextMetric1;
                surv0                <= nextSurv0;
                surv1                <= nextSurv1;
                bestState            <= nextBest;
                decision             <= nextDecision;
                oneOrZeroPredecessor <= pred1;
                dac0Data             <= dacMux(dac0Select);
                dac1Data             <= dacMux(dac1Select);
                dac2Data             <= dacMux(dac2Select);
            end
        end
    end

    // Register-bus writes with per-byte-lane enables
    always_ff @(posedge clk) begin
        if (reset) begin
            amp  <= 16'h4000;
            ctrl <= 2'b00;
        end else if (addrHit) begin
            if (addr[3:2] == 2'd0) begin
                if (wr0) amp[7:0]  <= din[7:0];
                if (wr1) amp[15:8] <= din[15:8];
            end else if (addr[3:2] == 2'd1) begin
                if (wr0) ctrl <= din[1:0];
            end
        end
    end

    // Register-bus readback, zero when not addressed
    always_comb begin
        dout = '0;
        if (addrHit) begin
            case (addr[3:2])
                2'd0:    dout = {16'b0, amp};
                2'd1:    dout = {30'b0, ctrl};
                2'd2:    dout = {30'b0, bestState, decision};
                default: dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_trellis_soqpsk.sv
// Bench for trellis_soqpsk: path-history Viterbi model plus directed literal checks.
module tb_trellis_soqpsk;

    localparam int TBD = 12;
    localparam logic [17:0] PLUS  = 18'h10000;
    localparam logic [17:0] MINUS = 18'h30000;

    logic        clk = 1'b0;
    logic        reset, symEn, sym2xEn;
    logic [17:0] iIn, qIn;
    logic        wr0, wr1, wr2, wr3;
    logic [12:0] addr;
    logic [31:0] din, dout;
    logic [3:0]  dac0Select, dac1Select, dac2Select;
    logic        dac0Sync, dac1Sync, dac2Sync;
    logic [17:0] dac0Data, dac1Data, dac2Data;
    logic        decision, sym2xEn_out, oneOrZeroPredecessor;

    int checks   = 0;
    int failures = 0;

    // model state: unbounded metrics and full path histories per state
    longint      mM0, mM1;
    bit          path0[$];
    bit          path1[$];
    int          stepCnt;
    logic [15:0] mAmp;
    logic [1:0]  mCtrl;
    logic        eSync, eDec, ePred, eBest;
    logic [17:0] eDac0, eDac1, eDac2;
    bit          cmpEn = 1'b0;
    int          framePos = 0;

    trellis_soqpsk #(.TB_DEPTH(TBD), .ADDR_BASE(13'h0400)) dut (
        .clk(clk), .reset(reset), .symEn(symEn), .sym2xEn(sym2xEn),
        .iIn(iIn), .qIn(qIn),
        .wr0(wr0), .wr1(wr1), .wr2(wr2), .wr3(wr3),
        .addr(addr), .din(din), .dout(dout),
        .dac0Select(dac0Select), .dac1Select(dac1Select), .dac2Select(dac2Select),
        .dac0Sync(dac0Sync), .dac1Sync(dac1Sync), .dac2Sync(dac2Sync),
        .dac0Data(dac0Data), .dac1Data(dac1Data), .dac2Data(dac2Data),
        .decision(decision), .sym2xEn_out(sym2xEn_out),
        .oneOrZeroPredecessor(oneOrZeroPredecessor)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] expDac(input logic [3:0] sel, input logic [17:0] i,
                                           input logic [17:0] q, input logic [17:0] s,
                                           input longint diff, input logic dec);
        case (sel)
            4'd0: return i;
            4'd1: return q;
            4'd2: return s;
            4'd3: begin
                if (diff > 131071)       return 18'h1FFFF;
                else if (diff < -131072) return 18'h20000;
                else                     return 18'(diff);
            end
            4'd4: return dec ? 18'h1FFFF : 18'h20001;
            default: return 18'h0;
        endcase
    endfunction

    task automatic modelReset();
        mM0 = 0; mM1 = 0;
        path0.delete(); path1.delete();
        stepCnt = 0;
        mAmp = 16'h4000; mCtrl = 2'b00;
        eSync = 0; eDec = 0; ePred = 0; eBest = 0;
        eDac0 = 0; eDac1 = 0; eDac2 = 0;
    endtask

    // one maximum-likelihood step: best path into each state, decision from history
    task automatic modelStep(input logic se, input logic [17:0] i, input logic [17:0] q);
        logic [17:0] smp;
        longint s, a, c11, c00, n0, n1;
        bit p1, p0, traced;
        bit q0[$];
        bit q1[$];
        smp = (se ^ mCtrl[1]) ? i : q;
        s   = longint'($signed(smp));
        a   = longint'(mAmp);
        c11 = mM1 + 2*s - 2*a;
        c00 = mM0 - 2*s - 2*a;
        p1  = (c11 >= mM0);
        p0  = (mM1 > c00);
        n1  = p1 ? c11 : mM0;
        n0  = p0 ? mM1 : c00;
        if (p1) q1 = path1; else q1 = path0;
        q1.push_back(1'b1);
        if (p0) q0 = path1; else q0 = path0;
        q0.push_back(1'b0);
        mM0 = n0; mM1 = n1; path0 = q0; path1 = q1;
        stepCnt++;
        eBest  = (n1 > n0);
        traced = 1'b0;
        if (stepCnt >= TBD) traced = eBest ? path1[stepCnt-TBD] : path0[stepCnt-TBD];
        eDec  = traced ^ mCtrl[0];
        ePred = p1;
        eDac0 = expDac(dac0Select, i, q, smp, n1 - n0, eDec);
        eDac1 = expDac(dac1Select, i, q, smp, n1 - n0, eDec);
        eDac2 = expDac(dac2Select, i, q, smp, n1 - n0, eDec);
    endtask

    task automatic cycle(input logic rst, input logic se, input logic s2,
                         input logic [17:0] i, input logic [17:0] q);
        reset = rst; symEn = se; sym2xEn = s2; iIn = i; qIn = q;
        if (rst) modelReset();
        else begin
            eSync = s2;
            if (s2) modelStep(se, i, q);
        end
        @(negedge clk);
    endtask

    // 18-clk frame, strobes on 0/4/8/13, on-time samples on 0/8
    task automatic runSteps(input int n, input int mode);
        int done = 0;
        while (done < n) begin
            logic strobe, onTime;
            logic [17:0] v;
            strobe = (framePos == 0) || (framePos == 4) || (framePos == 8) || (framePos == 13);
            onTime = (framePos == 0) || (framePos == 8);
            case (mode)
                0:       v = PLUS;
                1:       v = MINUS;
                default: v = (stepCnt % 2 == 0) ? PLUS : MINUS;
            endcase
            framePos = (framePos == 17) ? 0 : framePos + 1;
            if (strobe) done++;
            cycle(1'b0, onTime && strobe, strobe, v, v);
        end
    endtask

    task automatic busWrite(input logic [12:0] a, input logic [31:0] d, input logic [3:0] we);
        addr = a; din = d; {wr3, wr2, wr1, wr0} = we;
        if (a[12:4] == 9'h040) begin
            if (a[3:2] == 2'd0) begin
                if (we[0]) mAmp[7:0]  = d[7:0];
                if (we[1]) mAmp[15:8] = d[15:8];
            end else if (a[3:2] == 2'd1 && we[0]) begin
                mCtrl = d[1:0];
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 18'h0, 18'h0);
        {wr3, wr2, wr1, wr0} = 4'b0; addr = 13'h0; din = 32'h0;
    endtask

    task automatic readChk(input logic [12:0] a, input logic [31:0] exp, input string name);
        addr = a;
        #1;
        check(name, dout, exp);
        addr = 13'h0;
    endtask

    // every-cycle comparison against the model, just after the active edge
    always @(posedge clk) begin
        #1;
        if (cmpEn) begin
            check("sym2xEn_out", sym2xEn_out, eSync);
            check("dac0Sync", dac0Sync, eSync);
            check("dac1Sync", dac1Sync, eSync);
            check("dac2Sync", dac2Sync, eSync);
            check("decision", decision, eDec);
            check("oneOrZeroPredecessor", oneOrZeroPredecessor, ePred);
            check("dac0Data", dac0Data, eDac0);
            check("dac1Data", dac1Data, eDac1);
            check("dac2Data", dac2Data, eDac2);
        end
    end

    initial begin
        reset = 1; symEn = 0; sym2xEn = 0; iIn = 0; qIn = 0;
        wr0 = 0; wr1 = 0; wr2 = 0; wr3 = 0; addr = 0; din = 0;
        dac0Select = 0; dac1Select = 0; dac2Select = 0;
        modelReset();
        @(negedge clk);
        cmpEn = 1'b1;

        // reset state
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check("rst_decision", decision, 0);
        check("rst_sync", sym2xEn_out, 0);
        check("rst_pred", oneOrZeroPredecessor, 0);
        check("rst_dac0", dac0Data, 0);
        readChk(13'h0400, 32'h00004000, "rd_amp_rst");
        readChk(13'h0404, 32'h0, "rd_ctrl_rst");
        readChk(13'h0408, 32'h0, "rd_status_rst");
        readChk(13'h040C, 32'h0, "rd_reserved");

        // all ones
        dac0Select = 3; dac1Select = 0; dac2Select = 4;
        runSteps(11, 0);
        check("ones_dec_step11", decision, 0);
        runSteps(1, 0);
        check("ones_dec_step12", decision, 1);
        runSteps(28, 0);
        check("ones_dec", decision, 1);
        check("ones_pred", oneOrZeroPredecessor, 1);
        check("ones_dac_diff", dac0Data, 18'h18000);
        check("ones_dac_dec", dac2Data, 18'h1FFFF);
        readChk(13'h0408, 32'h3, "ones_status");

        // all zeros
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        runSteps(40, 1);
        check("zeros_dec", decision, 0);
        check("zeros_pred", oneOrZeroPredecessor, 0);
        check("zeros_dac_diff", dac0Data, 18'h28000);
        check("zeros_dac_dec", dac2Data, 18'h20001);
        readChk(13'h0408, 32'h0, "zeros_status");

        // alternating
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        runSteps(39, 2);
        check("alt_dec_step39", decision, 1);
        runSteps(1, 2);
        check("alt_dec_step40", decision, 0);
        check("alt_pred_step40", oneOrZeroPredecessor, 0);
        check("alt_dac_diff", dac0Data, 18'h28000);
        readChk(13'h0408, {30'b0, eBest, eDec}, "alt_status");

        // register bus
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        busWrite(13'h0400, 32'h0000AB77, 4'b0010);
        readChk(13'h0400, 32'h0000AB00, "rd_amp_lane1");
        busWrite(13'h0400, 32'hFFFF4000, 4'b1111);
        readChk(13'h0400, 32'h00004000, "rd_amp_full");
        busWrite(13'h0404, 32'h00000003, 4'b0001);
        readChk(13'h0404, 32'h00000003, "rd_ctrl");
        busWrite(13'h0404, 32'h00000000, 4'b0010);
        readChk(13'h0404, 32'h00000003, "rd_ctrl_nolane0");
        readChk(13'h0410, 32'h0, "rd_outside");
        runSteps(11, 0);
        check("inv_dec_step11", decision, 1);
        runSteps(29, 0);
        check("inv_dec", decision, 0);

        // DAC channels (swap still active)
        dac0Select = 0; dac1Select = 1; dac2Select = 2;
        cycle(0, 0, 1, 18'h00111, 18'h12345);
        check("dac1_q", dac1Data, 18'h12345);
        check("dac1_sync_hi", dac1Sync, 1);
        check("dac0_i", dac0Data, 18'h00111);
        check("dac2_swapped_s", dac2Data, 18'h00111);
        cycle(0, 0, 0, 0, 0);
        check("dac1_sync_lo", dac1Sync, 0);
        check("dac1_hold", dac1Data, 18'h12345);
        dac1Select = 7;
        cycle(0, 0, 1, PLUS, PLUS);
        check("dac1_sel7", dac1Data, 18'h0);

        // back-to-back strobes
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < 15; k++) begin
            cycle(0, (k % 2) == 0, 1, PLUS, PLUS);
            if (k == 10) check("b2b_dec_step11", decision, 0);
            if (k == 11) check("b2b_dec_step12", decision, 1);
        end
        check("b2b_sync_hi", sym2xEn_out, 1);
        cycle(0, 0, 0, 0, 0);
        check("b2b_sync_lo", sym2xEn_out, 0);

        // reset mid-stream, asserted together with a strobe
        runSteps(5, 0);
        cycle(1, 1, 1, PLUS, PLUS);
        check("midrst_sync", sym2xEn_out, 0);
        check("midrst_dec", decision, 0);
        check("midrst_pred", oneOrZeroPredecessor, 0);
        runSteps(11, 0);
        check("midrst_dec_step11", decision, 0);
        runSteps(1, 0);
        check("midrst_dec_step12", decision, 1);

        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
